// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master SRAM port arbiter (mem_port_arbiter).
// Request fields are sized for the widest supported data bus; users slice down.
package mem_arb_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_owner_e;

    localparam int unsigned ARB_N_MASTERS       = 2;
    localparam int unsigned ARB_ADDR_WIDTH      = 32;
    localparam int unsigned ARB_MAX_DATA_WIDTH  = 64;
    localparam int unsigned ARB_MAX_BE_WIDTH    = ARB_MAX_DATA_WIDTH / 8;

    typedef struct packed {
        logic [ARB_ADDR_WIDTH-1:0]     addr;
        logic                          we;
        logic [ARB_MAX_BE_WIDTH-1:0]   be;
        logic [ARB_MAX_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    function automatic mem_req_t mem_req_pack(
        input logic [ARB_ADDR_WIDTH-1:0]     addr,
        input logic                          we,
        input logic [ARB_MAX_BE_WIDTH-1:0]   be,
        input logic [ARB_MAX_DATA_WIDTH-1:0] wdata
    );
        mem_req_t r;
        r.addr  = addr;
        r.we    = we;
        r.be    = be;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic arb_owner_e arb_other(input arb_owner_e o);
        return (o == ARB_M0) ? ARB_M1 : ARB_M0;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection for mem_port_arbiter: fixed priority with M1 starvation guard,
// or round-robin when MEM_PORT_ARBITER_RR_EN is defined.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ARB_N_MASTERS-1:0] req,
    output arb_owner_e               winner,
    output logic [ARB_N_MASTERS-1:0] gnt
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_owner_e pref;

`ifdef MEM_PORT_ARBITER_RR_EN
    arb_owner_e       rr_ptr_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             unused_starve;

    assign starve_cnt_q  = '0;
    assign unused_starve = ^starve_cnt_q;
    assign pref          = rr_ptr_q;

    // Pointer always names the master that lost (or sat out) the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= ARB_M0;
        end else if (|req) begin
            rr_ptr_q <= arb_other(winner);
        end
    end
`else
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign pref = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? ARB_M1 : ARB_M0;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req[1] || gnt[1]) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        winner = ARB_M0;
        if (req[0] && req[1]) begin
            winner = pref;
        end else if (req[1]) begin
            winner = ARB_M1;
        end
        gnt    = '0;
        gnt[0] = req[0] && (winner == ARB_M0);
        gnt[1] = req[1] && (winner == ARB_M1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master req/gnt/rvalid arbiter in front of a 1-cycle-latency single-port SRAM.
// Define MEM_PORT_ARBITER_RR_EN for round-robin instead of fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    input  logic [31:0]               m0_addr_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    input  logic [31:0]               m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,

    output logic                      mem_en_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [ARB_N_MASTERS-1:0] req_vec;
    logic [ARB_N_MASTERS-1:0] gnt;
    arb_owner_e               winner;
    mem_req_t                 m0_req_s;
    mem_req_t                 m1_req_s;
    mem_req_t                 sel_req;
    logic                     rsp_valid_q;
    arb_owner_e               rsp_owner_q;
    logic                     unused_sel;

    // Requests are masked while rst is high so grants and the SRAM enable drop at once.
    assign req_vec = rst ? '0 : {m1_req_i, m0_req_i};

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vec),
        .winner (winner),
        .gnt    (gnt)
    );

    assign m0_req_s = mem_req_pack(m0_addr_i, m0_we_i, ARB_MAX_BE_WIDTH'(m0_be_i),
                                   ARB_MAX_DATA_WIDTH'(m0_wdata_i));
    assign m1_req_s = mem_req_pack(m1_addr_i, m1_we_i, ARB_MAX_BE_WIDTH'(m1_be_i),
                                   ARB_MAX_DATA_WIDTH'(m1_wdata_i));
    assign sel_req  = (winner == ARB_M1) ? m1_req_s : m0_req_s;

    // Byte-offset and high address bits are deliberately dropped (no decode).
    assign unused_sel = ^{sel_req.addr, sel_req.be, sel_req.wdata};

    always_comb begin
        m0_gnt_o    = gnt[0];
        m1_gnt_o    = gnt[1];
        mem_en_o    = |gnt;
        mem_addr_o  = sel_req.addr[MEM_ADDR_WIDTH+1:2];
        mem_we_o    = mem_en_o && sel_req.we;
        mem_be_o    = mem_en_o ? sel_req.be[BE_W-1:0] : '0;
        mem_wdata_o = sel_req.wdata[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= ARB_M0;
        end else begin
            rsp_valid_q <= |gnt;
            rsp_owner_q <= winner;
        end
    end

    always_comb begin
        m0_rvalid_o = rsp_valid_q && (rsp_owner_q == ARB_M0);
        m1_rvalid_o = rsp_valid_q && (rsp_owner_q == ARB_M1);
        m0_rdata_o  = mem_rdata_i;
        m1_rdata_o  = mem_rdata_i;
    end

endmodule
